rvfi_fairness_gen: RTL and testbench

//  Parametrised fairness monitor for the riscv-formal harness. Bounds grant latency,

---
 rtl/rvfi_fairness_pkg.sv | 18 +
 rtl/rvfi_fair_chan.sv | 63 ++++++
 rtl/rvfi_fairness_gen.sv | 144 ++++++++++++++
 tb/tb_rvfi_fairness_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rvfi_fairness_pkg.sv
// Shared cause codes and mode constants for the RVFI fairness monitor.
package rvfi_fairness_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_DELAY  = 3'd1,
    CAUSE_DROP   = 3'd2,
    CAUSE_ERRPOS = 3'd3,
    CAUSE_ERR    = 3'd4,
    CAUSE_INT    = 3'd5
  } cause_e;

  localparam int ERR_NONE    = 0;
  localparam int ERR_BOUNDED = 1;
  localparam int INT_NONE    = 0;
  localparam int INT_SPACED  = 1;

endpackage

// File: rtl/rvfi_fair_chan.sv
// One req/gnt/err channel: stall and error counters plus the per-cycle
// DELAY/DROP/ERRPOS/ERR conditions (combinational, unmasked).
module rvfi_fair_chan
  import rvfi_fairness_pkg::*;
#(
  parameter int CNT_W     = 5,
  parameter int MAX_DELAY = 5,
  parameter int ERR_MODE  = 0,
  parameter int MAX_ERRS  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             gnt,
  input  logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             cond_delay,
  output logic             cond_drop,
  output logic             cond_errpos,
  output logic             cond_err
);

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             prev_stall_q;
  logic             prev_grant_q;
  logic             stall;
  logic             grant;
  logic             resp_err;
  logic             err_full;

  assign stall    = req & ~gnt;
  assign grant    = req & gnt;
  // A response error is only legal in the cycle right after a grant.
  assign resp_err = err & prev_grant_q;
  assign err_full = (err_cnt_q == CNT_W'(MAX_ERRS));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_q      <= '0;
      err_cnt_q    <= '0;
      prev_stall_q <= 1'b0;
      prev_grant_q <= 1'b0;
    end else begin
      if (stall) begin
        if (stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
      end else begin
        stall_q <= '0;
      end
      if (resp_err && (ERR_MODE == ERR_BOUNDED) && !err_full)
        err_cnt_q <= err_cnt_q + 1'b1;
      prev_stall_q <= stall;
      prev_grant_q <= grant;
    end
  end

  assign stall_cnt   = stall_q;
  assign cond_delay  = stall & (stall_q == CNT_W'(MAX_DELAY));
  assign cond_drop   = ~req & prev_stall_q;
  assign cond_errpos = err & ~prev_grant_q;
  assign cond_err    = resp_err & ((ERR_MODE == ERR_NONE) | err_full);

endmodule

// File: rtl/rvfi_fairness_gen.sv
// Fairness monitor top: per-channel checkers, interrupt pacing, first-cause
// capture and sticky violation flags.
module rvfi_fairness_gen
  import rvfi_fairness_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int CNT_W      = 5,
  parameter int MAX_DELAY  = 5,
  parameter int ERR_MODE   = 0,
  parameter int MAX_ERRS   = 1,
  parameter int INT_MODE   = 0,
  parameter int INT_GAP    = 16,
  parameter int USE_ASSUME = 1,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic [NCH-1:0]       ch_req,
  input  logic [NCH-1:0]       ch_gnt,
  input  logic [NCH-1:0]       ch_err,
  input  logic                 int_sw,
  input  logic                 int_ext,
  output logic [NCH*CNT_W-1:0] ch_stall_cnt,
  output logic [NCH-1:0]       ch_viol,
  output logic                 int_viol,
  output logic                 any_viol,
  output logic [2:0]           viol_cause,
  output logic [CH_W-1:0]      viol_chan
);

  logic [NCH-1:0]   c_delay, c_drop, c_errpos, c_err;
  logic [NCH-1:0]   m_delay, m_drop, m_errpos, m_err;
  logic [NCH-1:0]   chan_fault;
  logic             irq, irq_q, irq_rise, gap_short;
  logic [CNT_W-1:0] gap_q;
  logic             c_int_raw, c_int;
  cause_e           first_cause;
  logic [CH_W-1:0]  first_chan;
  logic [NCH-1:0]   ch_viol_q;
  logic             int_viol_q, any_viol_q;
  cause_e           cause_q;
  logic [CH_W-1:0]  chan_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    rvfi_fair_chan #(
      .CNT_W     (CNT_W),
      .MAX_DELAY (MAX_DELAY),
      .ERR_MODE  (ERR_MODE),
      .MAX_ERRS  (MAX_ERRS)
    ) u_chan (
      .clk         (g_clk),
      .resetn      (g_resetn),
      .req         (ch_req[i]),
      .gnt         (ch_gnt[i]),
      .err         (ch_err[i]),
      .stall_cnt   (ch_stall_cnt[i*CNT_W +: CNT_W]),
      .cond_delay  (c_delay[i]),
      .cond_drop   (c_drop[i]),
      .cond_errpos (c_errpos[i]),
      .cond_err    (c_err[i])
    );
  end

  // gap_q counts cycles since the last rising edge; it holds 1 in the cycle
  // after an edge so an edge exactly INT_GAP cycles later is accepted.
  assign irq       = int_sw | int_ext;
  assign irq_rise  = irq & ~irq_q;
  assign gap_short = (gap_q < CNT_W'(INT_GAP));
  assign c_int_raw = (INT_MODE == INT_NONE) ? irq : (irq_rise & gap_short);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      irq_q <= 1'b0;
      gap_q <= {CNT_W{1'b1}};
    end else begin
      irq_q <= irq;
      if (irq_rise)                     gap_q <= CNT_W'(1);
      else if (gap_q != {CNT_W{1'b1}})  gap_q <= gap_q + 1'b1;
    end
  end

  assign m_delay    = c_delay  & {NCH{g_resetn}};
  assign m_drop     = c_drop   & {NCH{g_resetn}};
  assign m_errpos   = c_errpos & {NCH{g_resetn}};
  assign m_err      = c_err    & {NCH{g_resetn}};
  assign c_int      = c_int_raw & g_resetn;
  assign chan_fault = m_delay | m_drop | m_errpos | m_err;

  // Scanned from highest code / highest channel down so the last hit wins,
  // leaving the lowest code and then the lowest channel.
  always_comb begin
    first_cause = CAUSE_NONE;
    first_chan  = '0;
    if (c_int) first_cause = CAUSE_INT;
    for (int i = NCH - 1; i >= 0; i--)
      if (m_err[i]) begin first_cause = CAUSE_ERR; first_chan = CH_W'(i); end
    for (int i = NCH - 1; i >= 0; i--)
      if (m_errpos[i]) begin first_cause = CAUSE_ERRPOS; first_chan = CH_W'(i); end
    for (int i = NCH - 1; i >= 0; i--)
      if (m_drop[i]) begin first_cause = CAUSE_DROP; first_chan = CH_W'(i); end
    for (int i = NCH - 1; i >= 0; i--)
      if (m_delay[i]) begin first_cause = CAUSE_DELAY; first_chan = CH_W'(i); end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      ch_viol_q  <= '0;
      int_viol_q <= 1'b0;
      any_viol_q <= 1'b0;
      cause_q    <= CAUSE_NONE;
      chan_q     <= '0;
    end else begin
      ch_viol_q  <= ch_viol_q | chan_fault;
      int_viol_q <= int_viol_q | c_int;
      any_viol_q <= any_viol_q | (|chan_fault) | c_int;
      if ((cause_q == CAUSE_NONE) && (first_cause != CAUSE_NONE)) begin
        cause_q <= first_cause;
        chan_q  <= first_chan;
      end
    end
  end

  assign ch_viol    = ch_viol_q;
  assign int_viol   = int_viol_q;
  assign any_viol   = any_viol_q;
  assign viol_cause = cause_q;
  assign viol_chan  = chan_q;

  if (USE_ASSUME != 0) begin : g_assume
`ifdef FORMAL
    initial assume (!g_resetn);
    always_comb begin
      if (g_resetn) begin
        assume (!(|c_delay));
        assume (!(|c_drop));
        assume (!(|c_errpos));
        assume (!(|c_err));
        assume (!c_int_raw);
      end
    end
`endif
  end

endmodule

// File: tb/tb_rvfi_fairness_gen.sv
// Directed bench for rvfi_fairness_gen: default, error-budget and spaced-interrupt builds.
module tb_rvfi_fairness_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       g_resetn;
  logic [1:0] ch_req, ch_gnt, ch_err;
  logic       int_sw, int_ext;

  logic [9:0] a_stall, e_stall, i_stall;
  logic [1:0] a_ch_viol, e_ch_viol, i_ch_viol;
  logic       a_int_viol, e_int_viol, i_int_viol;
  logic       a_any, e_any, i_any;
  logic [2:0] a_cause, e_cause, i_cause;
  logic [0:0] a_chan, e_chan, i_chan;

  int checks = 0;
  int errors = 0;

  rvfi_fairness_gen #(.USE_ASSUME(0)) dut_a (
    .g_clk(clk), .g_resetn(g_resetn), .ch_req(ch_req), .ch_gnt(ch_gnt), .ch_err(ch_err),
    .int_sw(int_sw), .int_ext(int_ext), .ch_stall_cnt(a_stall), .ch_viol(a_ch_viol),
    .int_viol(a_int_viol), .any_viol(a_any), .viol_cause(a_cause), .viol_chan(a_chan)
  );

  rvfi_fairness_gen #(.ERR_MODE(1), .MAX_ERRS(1), .USE_ASSUME(0)) dut_e (
    .g_clk(clk), .g_resetn(g_resetn), .ch_req(ch_req), .ch_gnt(ch_gnt), .ch_err(ch_err),
    .int_sw(int_sw), .int_ext(int_ext), .ch_stall_cnt(e_stall), .ch_viol(e_ch_viol),
    .int_viol(e_int_viol), .any_viol(e_any), .viol_cause(e_cause), .viol_chan(e_chan)
  );

  rvfi_fairness_gen #(.INT_MODE(1), .INT_GAP(16), .USE_ASSUME(0)) dut_i (
    .g_clk(clk), .g_resetn(g_resetn), .ch_req(ch_req), .ch_gnt(ch_gnt), .ch_err(ch_err),
    .int_sw(int_sw), .int_ext(int_ext), .ch_stall_cnt(i_stall), .ch_viol(i_ch_viol),
    .int_viol(i_int_viol), .any_viol(i_any), .viol_cause(i_cause), .viol_chan(i_chan)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    ch_req = '0; ch_gnt = '0; ch_err = '0;
    int_sw = 1'b0; int_ext = 1'b0;
    tick();
    tick();
    g_resetn = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_stall", 32'(a_stall), 0);
    chk("rst_chviol", 32'(a_ch_viol), 0);
    chk("rst_intviol", 32'(a_int_viol), 0);
    chk("rst_any", 32'(a_any), 0);
    chk("rst_cause", 32'(a_cause), 0);
    chk("rst_chan", 32'(a_chan), 0);

    // ch0: five stalls then grant is legal
    ch_req = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("c0_stall_cnt", 32'(a_stall[4:0]), k);
    end
    ch_gnt = 2'b01;
    tick();
    chk("c0_cnt_after_gnt", 32'(a_stall[4:0]), 0);
    chk("c0_no_viol", 32'(a_ch_viol), 0);
    ch_req = '0; ch_gnt = '0;
    tick();
    chk("c0_no_any", 32'(a_any), 0);
    chk("c0_no_cause", 32'(a_cause), 0);

    // ch1: sixth stall is a DELAY fault
    ch_req = 2'b10;
    repeat (5) tick();
    chk("c1_5stall_ok", 32'(a_ch_viol), 0);
    tick();
    chk("c1_delay_chviol", 32'(a_ch_viol), 2);
    chk("c1_delay_any", 32'(a_any), 1);
    chk("c1_delay_cause", 32'(a_cause), 1);
    chk("c1_delay_chan", 32'(a_chan), 1);
    chk("c1_stall_cnt6", 32'(a_stall[9:5]), 6);

    // ch0: request withdrawn after two stalls
    do_reset();
    ch_req = 2'b01;
    tick();
    tick();
    chk("drop_pre", 32'(a_ch_viol), 0);
    ch_req = '0;
    tick();
    chk("drop_chviol", 32'(a_ch_viol), 1);
    chk("drop_cause", 32'(a_cause), 2);
    chk("drop_chan", 32'(a_chan), 0);

    // ERR_MODE=1, MAX_ERRS=1: first resp error tolerated, second flagged
    do_reset();
    ch_req = 2'b01; ch_gnt = 2'b01;
    tick();
    ch_req = '0; ch_gnt = '0; ch_err = 2'b01;
    tick();
    chk("err1_no_viol", 32'(e_ch_viol), 0);
    chk("err1_no_any", 32'(e_any), 0);
    ch_err = '0; ch_req = 2'b01; ch_gnt = 2'b01;
    tick();
    ch_req = '0; ch_gnt = '0; ch_err = 2'b01;
    tick();
    chk("err2_chviol", 32'(e_ch_viol), 1);
    chk("err2_cause", 32'(e_cause), 4);
    ch_err = '0;

    // error outside a response cycle
    do_reset();
    ch_err = 2'b01;
    tick();
    chk("errpos_chviol", 32'(e_ch_viol), 1);
    chk("errpos_cause", 32'(e_cause), 3);
    ch_err = '0;

    // INT_MODE=1, INT_GAP=16: edges at t=0 and t=16 legal, t=20 too soon
    do_reset();
    int_ext = 1'b1;
    tick();
    chk("int_t0", 32'(i_int_viol), 0);
    int_ext = 1'b0;
    repeat (15) tick();
    int_ext = 1'b1;
    tick();
    chk("int_t16", 32'(i_int_viol), 0);
    chk("int_t16_any", 32'(i_any), 0);
    int_ext = 1'b0;
    repeat (3) tick();
    int_ext = 1'b1;
    tick();
    chk("int_t20_viol", 32'(i_int_viol), 1);
    chk("int_t20_cause", 32'(i_cause), 5);
    chk("int_t20_chan", 32'(i_chan), 0);
    chk("int_t20_any", 32'(i_any), 1);
    int_ext = 1'b0;

    // same-cycle DELAY on ch1 and INT fault: DELAY wins the cause
    do_reset();
    ch_req = 2'b10;
    repeat (5) tick();
    int_sw = 1'b1;
    tick();
    chk("both_chviol", 32'(a_ch_viol), 2);
    chk("both_intviol", 32'(a_int_viol), 1);
    chk("both_cause", 32'(a_cause), 1);
    chk("both_chan", 32'(a_chan), 1);
    chk("both_any", 32'(a_any), 1);

    g_resetn = 1'b0;
    ch_req = '0; int_sw = 1'b0;
    tick();
    chk("clr_stall", 32'(a_stall), 0);
    chk("clr_chviol", 32'(a_ch_viol), 0);
    chk("clr_intviol", 32'(a_int_viol), 0);
    chk("clr_any", 32'(a_any), 0);
    chk("clr_cause", 32'(a_cause), 0);
    chk("clr_chan", 32'(a_chan), 0);
    g_resetn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
